// File: rtl/reference_model_if.sv
// CPU-side program-mode bus of the 8237-style DMA controller, plus the decode strobes
// the reference model derives from it.
interface reference_model_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              CS_N;
    logic              IOR_N;
    logic              IOW_N;
    logic [ADDR_W-1:0] A;
    logic              programCondition;

    logic              loadIoDataBufferFromDB;
    logic              loadIoDataBufferFromStatus;
    logic              readStatusReg;
    logic              readCurrentAddressReg;
    logic              readCurrentWordCountReg;
    logic              readTemporaryReg;
    logic              loadCommandReg;
    logic              loadModeReg;
    logic              loadRequestReg;
    logic              loadSingleMask;
    logic              loadAllMask;
    logic              clearMaskReg;
    logic              masterClear;
    logic              clearInternalFF;
    logic              loadBaseAddressReg;
    logic              loadBaseWordCountReg;
    logic [1:0]        channel;
    logic              upperByte;
    logic              internalFF;

    // CPU / bench side
    modport master (
        output CS_N, IOR_N, IOW_N, A, programCondition,
        input  loadIoDataBufferFromDB, loadIoDataBufferFromStatus,
        input  readStatusReg, readCurrentAddressReg, readCurrentWordCountReg, readTemporaryReg,
        input  loadCommandReg, loadModeReg, loadRequestReg, loadSingleMask, loadAllMask,
        input  clearMaskReg, masterClear, clearInternalFF,
        input  loadBaseAddressReg, loadBaseWordCountReg, channel, upperByte, internalFF
    );

    // Decode model side
    modport slave (
        input  CS_N, IOR_N, IOW_N, A, programCondition,
        output loadIoDataBufferFromDB, loadIoDataBufferFromStatus,
        output readStatusReg, readCurrentAddressReg, readCurrentWordCountReg, readTemporaryReg,
        output loadCommandReg, loadModeReg, loadRequestReg, loadSingleMask, loadAllMask,
        output clearMaskReg, masterClear, clearInternalFF,
        output loadBaseAddressReg, loadBaseWordCountReg, channel, upperByte, internalFF
    );
endinterface

// File: rtl/reference_model.sv
// Cycle-accurate decode model of the 8237 program-mode register interface: turns CPU
// read/write pulses into one-shot datapath strobes and tracks the byte-pointer flip-flop.
module reference_model #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic                CLK,
    input  logic                RESET_N,
    reference_model_if.slave    bus
);
    logic              w_wr_qual;
    logic              w_rd_qual;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_tog_ff;
    logic              w_clr_ff;

    logic              r_prev_wr;
    logic              r_prev_rd;
    logic              r_wr_pend;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_ff;
    logic              r_ff;

    assign w_wr_qual = bus.programCondition & ~bus.CS_N & ~bus.IOW_N & bus.IOR_N;
    assign w_rd_qual = bus.programCondition & ~bus.CS_N & ~bus.IOR_N & bus.IOW_N;

    // Accept only on the first qualified cycle; RESET_N gates the combinational strobes too
    assign w_wr_acc = RESET_N & w_wr_qual & ~r_prev_wr;
    assign w_rd_acc = RESET_N & w_rd_qual & ~r_prev_rd;

    assign w_tog_ff = (w_wr_acc | w_rd_acc) & ~bus.A[3];
    assign w_clr_ff = r_wr_pend &
                      ((r_wr_addr == ADDR_W'(12)) || (r_wr_addr == ADDR_W'(13)));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_prev_wr <= 1'b0;
            r_prev_rd <= 1'b0;
            r_wr_pend <= 1'b0;
            r_wr_addr <= '0;
            r_wr_ff   <= 1'b0;
            r_ff      <= 1'b0;
        end else begin
            r_prev_wr <= w_wr_qual;
            r_prev_rd <= w_rd_qual;
            r_wr_pend <= w_wr_acc;
            if (w_wr_acc) begin
                r_wr_addr <= bus.A;
                r_wr_ff   <= r_ff;
            end
            // Clear beats a simultaneous toggle
            if (w_clr_ff) begin
                r_ff <= 1'b0;
            end else if (w_tog_ff) begin
                r_ff <= ~r_ff;
            end
        end
    end

    always_comb begin
        bus.loadIoDataBufferFromDB     = w_wr_acc;
        bus.loadIoDataBufferFromStatus = 1'b0;
        bus.readStatusReg              = 1'b0;
        bus.readCurrentAddressReg      = 1'b0;
        bus.readCurrentWordCountReg    = 1'b0;
        bus.readTemporaryReg           = 1'b0;
        bus.loadCommandReg             = 1'b0;
        bus.loadModeReg                = 1'b0;
        bus.loadRequestReg             = 1'b0;
        bus.loadSingleMask             = 1'b0;
        bus.loadAllMask                = 1'b0;
        bus.clearMaskReg               = 1'b0;
        bus.masterClear                = 1'b0;
        bus.clearInternalFF            = 1'b0;
        bus.loadBaseAddressReg         = 1'b0;
        bus.loadBaseWordCountReg       = 1'b0;
        bus.channel                    = 2'd0;
        bus.upperByte                  = 1'b0;
        bus.internalFF                 = r_ff;

        // Write targets fire in the cycle after the accept, from registered address
        if (r_wr_pend) begin
            if (!r_wr_addr[3]) begin
                bus.loadBaseAddressReg   = ~r_wr_addr[0];
                bus.loadBaseWordCountReg = r_wr_addr[0];
                bus.channel              = r_wr_addr[2:1];
                bus.upperByte            = r_wr_ff;
            end else begin
                unique case (r_wr_addr[2:0])
                    3'd0: bus.loadCommandReg  = 1'b1;
                    3'd1: bus.loadRequestReg  = 1'b1;
                    3'd2: bus.loadSingleMask  = 1'b1;
                    3'd3: bus.loadModeReg     = 1'b1;
                    3'd4: bus.clearInternalFF = 1'b1;
                    3'd5: bus.masterClear     = 1'b1;
                    3'd6: bus.clearMaskReg    = 1'b1;
                    3'd7: bus.loadAllMask     = 1'b1;
                endcase
            end
        end

        if (w_rd_acc) begin
            if (!bus.A[3]) begin
                bus.readCurrentAddressReg   = ~bus.A[0];
                bus.readCurrentWordCountReg = bus.A[0];
                bus.channel                 = bus.A[2:1];
                bus.upperByte               = r_ff;
            end else if (bus.A == ADDR_W'(8)) begin
                bus.readStatusReg              = 1'b1;
                bus.loadIoDataBufferFromStatus = 1'b1;
            end else if (bus.A == ADDR_W'(13)) begin
                bus.readTemporaryReg = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reference_model.sv
// Directed bench for reference_model: expected strobe vectors are queued as stimulus is
// driven and popped when the outputs are sampled mid-cycle.
`timescale 1ns/1ps
module tb_reference_model;
    typedef struct packed {
        logic       ldb;
        logic       lds;
        logic       rsr;
        logic       rca;
        logic       rcw;
        logic       rtmp;
        logic       lcmd;
        logic       lmode;
        logic       lreq;
        logic       lsm;
        logic       lam;
        logic       cmr;
        logic       mc;
        logic       cff;
        logic       lba;
        logic       lbwc;
        logic [1:0] ch;
        logic       ub;
        logic       ff;
    } out_t;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    out_t sb[$];

    reference_model_if #(.ADDR_W(4)) bus ();

    reference_model #(.ADDR_W(4)) u_dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic out_t observe();
        out_t o;
        o.ldb   = bus.loadIoDataBufferFromDB;
        o.lds   = bus.loadIoDataBufferFromStatus;
        o.rsr   = bus.readStatusReg;
        o.rca   = bus.readCurrentAddressReg;
        o.rcw   = bus.readCurrentWordCountReg;
        o.rtmp  = bus.readTemporaryReg;
        o.lcmd  = bus.loadCommandReg;
        o.lmode = bus.loadModeReg;
        o.lreq  = bus.loadRequestReg;
        o.lsm   = bus.loadSingleMask;
        o.lam   = bus.loadAllMask;
        o.cmr   = bus.clearMaskReg;
        o.mc    = bus.masterClear;
        o.cff   = bus.clearInternalFF;
        o.lba   = bus.loadBaseAddressReg;
        o.lbwc  = bus.loadBaseWordCountReg;
        o.ch    = bus.channel;
        o.ub    = bus.upperByte;
        o.ff    = bus.internalFF;
        return o;
    endfunction

    task automatic check(input string tag);
        out_t got;
        out_t want;
        got = observe();
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed=%h expected=<none>", tag, got);
        end else begin
            want = sb.pop_front();
            assert (got === want) else begin
                n_fail++;
                $error("FAIL %s: observed=%h expected=%h", tag, got, want);
            end
        end
    endtask

    task automatic step(input logic rst, input logic cs, input logic ior, input logic iow,
                        input logic [3:0] a, input logic pc, input out_t exp,
                        input string tag);
        @(negedge clk);
        rst_n                = rst;
        bus.CS_N             = cs;
        bus.IOR_N            = ior;
        bus.IOW_N            = iow;
        bus.A                = a;
        bus.programCondition = pc;
        sb.push_back(exp);
        #4;
        check(tag);
    endtask

    task automatic wr(input logic [3:0] a, input out_t exp, input string tag);
        step(1'b1, 1'b0, 1'b1, 1'b0, a, 1'b1, exp, tag);
    endtask

    task automatic rd(input logic [3:0] a, input out_t exp, input string tag);
        step(1'b1, 1'b0, 1'b0, 1'b1, a, 1'b1, exp, tag);
    endtask

    task automatic idle(input out_t exp, input string tag);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, exp, tag);
    endtask

    initial begin
        out_t        e;
        logic [3:0]  wa [5];
        wa = '{4'h9, 4'hA, 4'hB, 4'hE, 4'hF};

        rst_n                = 1'b0;
        bus.CS_N             = 1'b1;
        bus.IOR_N            = 1'b1;
        bus.IOW_N            = 1'b1;
        bus.A                = 4'h0;
        bus.programCondition = 1'b1;

        // Reset state and asynchronous reset in the middle of a write pulse
        e = '0;
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, e, "reset_idle");
        idle(e, "after_release");
        e = '0; e.ldb = 1'b1;
        wr(4'h8, e, "rst_wr_accept");
        #2 rst_n = 1'b0;
        e = '0;
        sb.push_back(e);
        #1 check("rst_async_outputs");
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'h8, 1'b1, e, "rst_held");
        idle(e, "rst_no_pending");
        idle(e, "rst_idle2");

        // Command write held 3 cycles
        e = '0; e.ldb = 1'b1;  wr(4'h8, e, "cmd_t0");
        e = '0; e.lcmd = 1'b1; wr(4'h8, e, "cmd_t1");
        e = '0;                wr(4'h8, e, "cmd_t2");
        idle(e, "cmd_idle");

        // Address write to channel 2, both bytes
        e = '0; e.ldb = 1'b1; wr(4'h4, e, "addr_lo_t0");
        e = '0; e.lba = 1'b1; e.ch = 2'd2; e.ff = 1'b1; idle(e, "addr_lo_t1");
        e = '0; e.ldb = 1'b1; e.ff = 1'b1; wr(4'h4, e, "addr_hi_t0");
        e = '0; e.lba = 1'b1; e.ch = 2'd2; e.ub = 1'b1; idle(e, "addr_hi_t1");

        // Word-count write then clear flip-flop
        e = '0; e.ldb = 1'b1; wr(4'h1, e, "wc_t0");
        e = '0; e.lbwc = 1'b1; e.ff = 1'b1; idle(e, "wc_t1");
        e = '0; e.ldb = 1'b1; e.ff = 1'b1; wr(4'hC, e, "clrff_t0");
        e = '0; e.cff = 1'b1; e.ff = 1'b1; idle(e, "clrff_t1");
        e = '0; idle(e, "clrff_after");

        // Status read
        e = '0; e.lds = 1'b1; e.rsr = 1'b1; rd(4'h8, e, "status_t0");
        e = '0; rd(4'h8, e, "status_held");
        idle(e, "status_idle");

        // Current word-count / address reads on channel 1
        e = '0; e.rcw = 1'b1; e.ch = 2'd1; rd(4'h3, e, "rd_wc_ch1");
        e = '0; e.ff = 1'b1; idle(e, "rd_wc_ff");
        e = '0; e.rca = 1'b1; e.ch = 2'd1; e.ub = 1'b1; e.ff = 1'b1; rd(4'h2, e, "rd_addr_hi");
        e = '0; idle(e, "rd_addr_ff");
        e = '0; e.rtmp = 1'b1; rd(4'hD, e, "rd_temp");
        e = '0; idle(e, "rd_temp_idle");
        e = '0; rd(4'h9, e, "rd_unmapped");
        idle(e, "rd_unmapped_idle");

        // Illegal and disabled accesses leave internalFF at 1
        e = '0; e.ldb = 1'b1; wr(4'h0, e, "ill_setff_t0");
        e = '0; e.lba = 1'b1; e.ff = 1'b1; idle(e, "ill_setff_t1");
        e = '0; e.ff = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, e, "ill_both_low");
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, e, "ill_cs_high");
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, e, "ill_pc_low_rd");
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 1'b0, e, "ill_pc_low_wr");
        idle(e, "ill_idle");

        // Master clear resets the flip-flop
        e = '0; e.ldb = 1'b1; e.ff = 1'b1; wr(4'hD, e, "mclr_t0");
        e = '0; e.mc = 1'b1; e.ff = 1'b1; idle(e, "mclr_t1");
        e = '0; idle(e, "mclr_after");

        // Remaining write targets
        for (int i = 0; i < 5; i++) begin
            e = '0; e.ldb = 1'b1; wr(wa[i], e, "wmap_t0");
            e = '0;
            case (wa[i])
                4'h9:    e.lreq  = 1'b1;
                4'hA:    e.lsm   = 1'b1;
                4'hB:    e.lmode = 1'b1;
                4'hE:    e.cmr   = 1'b1;
                default: e.lam   = 1'b1;
            endcase
            idle(e, "wmap_t1");
        end

        // programCondition drops while the strobe is held: pending strobe still fires
        e = '0; e.ldb = 1'b1; wr(4'h9, e, "pc_fall_t0");
        e = '0; e.lreq = 1'b1;
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'h9, 1'b0, e, "pc_fall_t1");
        e = '0; step(1'b1, 1'b0, 1'b1, 1'b0, 4'h9, 1'b0, e, "pc_fall_t2");
        idle(e, "pc_fall_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reference_model.md
Name: reference_model

Overview:
- Cycle-accurate decode model of the 8237-style DMA controller's CPU-side (program-mode) register interface.
- Watches CS_N, IOR_N, IOW_N, A3..A0 and the DUT's programCondition, and produces the strobes the DMA datapath must generate: I/O data-buffer loads, register loads, register reads and byte-pointer flip-flop control.
- Instantiated beside the DMA controller; the controller's checker compares internal registers against these strobes.

Parameters:
- ADDR_W, 4, width of the register-select address (A3..A0).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- CS_N  input  1  chip select, active low.
- IOR_N  input  1  I/O read strobe, active low.
- IOW_N  input  1  I/O write strobe, active low.
- A  input  4  register select {A3,A2,A1,A0}.
- programCondition  input  1  high while the controller is in program (idle, CPU-access) condition.
- loadIoDataBufferFromDB  output  1  ioDataBuffer captures DB this cycle.
- loadIoDataBufferFromStatus  output  1  ioDataBuffer captures statusReg this cycle.
- readStatusReg, readCurrentAddressReg, readCurrentWordCountReg, readTemporaryReg  output  1 each  read-decode strobes.
- loadCommandReg, loadModeReg, loadRequestReg, loadSingleMask, loadAllMask, clearMaskReg, masterClear, clearInternalFF  output  1 each  write-target strobes.
- loadBaseAddressReg, loadBaseWordCountReg  output  1 each  base+current address/word-count load.
- channel  output  2  channel for address/count access (A2..A1).
- upperByte  output  1  1 = high byte of the 16-bit register is being accessed.
- internalFF  output  1  model of the byte-pointer flip-flop.

Behaviour:
- Qualified write: programCondition & !CS_N & !IOW_N & IOR_N.
- Qualified read: programCondition & !CS_N & !IOR_N & IOW_N.
- IOR_N and IOW_N both low = neither qualified; all strobes stay 0.
- An access is accepted only on the first cycle its qualifier is true, using a registered previous-qualifier bit. A held strobe gives exactly one accept.
- Write accept, cycle T:
  - loadIoDataBufferFromDB = 1 combinationally in T.
  - A and internalFF are registered.
  - The decoded target strobe is asserted for exactly one cycle in T+1, so targets load from ioDataBuffer.
- Write map:
  - A3=0: A0=0 → loadBaseAddressReg, A0=1 → loadBaseWordCountReg; channel = A[2:1].
  - 8 → loadCommandReg; 9 → loadRequestReg; A → loadSingleMask; B → loadModeReg.
  - C → clearInternalFF; D → masterClear; E → clearMaskReg; F → loadAllMask.
- Read accept, cycle T (all combinational in T):
  - A3=0: A0=0 → readCurrentAddressReg, A0=1 → readCurrentWordCountReg; channel = A[2:1].
  - 8 → readStatusReg and loadIoDataBufferFromStatus.
  - D → readTemporaryReg.
  - Other read addresses produce no strobe.
- channel and upperByte are combinational during read accepts and registered with the write target during T+1; 0 otherwise.
- upperByte = internalFF value at the accept cycle.
- internalFF:
  - Reset 0.
  - Toggles at the end of every accepted address/word-count read or write (A3=0).
  - Cleared when clearInternalFF or masterClear is issued (end of T+1).
  - A clear wins over a simultaneous toggle.
- masterClear behaves like reset for internalFF only.
- programCondition falling mid-pulse: nothing further is decoded. A pending T+1 strobe still fires.
- RESET_N low (any time, asynchronous): all outputs 0, internalFF 0, pipeline and previous-qualifier registers cleared. Pending T+1 strobes are discarded.
- All outputs are 0 whenever no accept or pending strobe exists; no X on any output after reset.

Test Plan:
- Reset: RESET_N=0 mid-write pulse → all outputs 0 immediately, internalFF=0, no T+1 strobe after release.
- Command write: CS_N=0, IOW_N=0 for 3 cycles, A=8, programCondition=1 → loadIoDataBufferFromDB=1 only in first cycle; loadCommandReg=1 exactly one cycle later.
- Address write, channel 2: two writes A=4 → first gives loadBaseAddressReg, channel=2, upperByte=0; second gives upperByte=1; internalFF returns to 0.
- Clear FF: write A=1 (internalFF→1), then write A=C → clearInternalFF pulse at T+1, internalFF=0 afterwards.
- Status read: IOR_N=0, A=8 → readStatusReg=1 and loadIoDataBufferFromStatus=1 same cycle; no write strobes.
- Illegal and disabled accesses: IOR_N=IOW_N=0, or CS_N=1, or programCondition=0 → all strobes 0, internalFF unchanged.
